// File: rtl/dmem_responder.sv
// Word-wide data SRAM responder for the MEM stage. It answers WAIT_CYCLES+1 cycles after accepting a request.
// It holds stall high while an access is outstanding and drops it in the response cycle, so the pipeline can advance.
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_ren,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            flush,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_err;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic            w_req;
  logic            w_err;
  logic            w_fire;
  logic            w_wr;
  logic [AW-1:0]   w_idx;

  assign w_req = req_ren | req_wen;
  assign w_idx = req_addr[AW+1:2];

  // DEPTH_WORDS is a power of two, so any set bit above the index field is out of range.
  assign w_err = (req_addr[1:0] != 2'b00) | (|req_addr[XLEN-1:AW+2]) | (req_ren & req_wen);

  assign w_fire = ((r_state == S_IDLE) && w_req && !flush && (WAIT_CYCLES == 0)) ||
                  ((r_state == S_WAIT) && !flush && (r_cnt == 4'd1));

  assign w_wr = w_fire & req_wen & ~w_err & rst_n;

  assign stall = w_req & (r_state != S_RESP) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req && !flush) begin
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_fire) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (req_ren && !w_err) ? r_mem[w_idx] : '0;
      end
    end
  end

  // SRAM array carries no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_idx] <= req_wdata;
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with three instances: WAIT_CYCLES = 0, 1 and 3 (index 0, 1, 2).
module tb_dmem_responder;

  logic        clk;
  logic [2:0]  rst_n;
  logic [2:0]  ren;
  logic [2:0]  wen;
  logic [2:0]  flush;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [2:0]  stall;
  logic [2:0]  vld;
  logic [2:0]  err;
  logic [31:0] rdata [3];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_resp;

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n[0]), .req_ren(ren[0]), .req_wen(wen[0]), .req_addr(addr[0]),
    .req_wdata(wdata[0]), .flush(flush[0]), .stall(stall[0]), .resp_valid(vld[0]),
    .resp_rdata(rdata[0]), .resp_err(err[0]));

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n[1]), .req_ren(ren[1]), .req_wen(wen[1]), .req_addr(addr[1]),
    .req_wdata(wdata[1]), .flush(flush[1]), .stall(stall[1]), .resp_valid(vld[1]),
    .resp_rdata(rdata[1]), .resp_err(err[1]));

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n[2]), .req_ren(ren[2]), .req_wen(wen[2]), .req_addr(addr[2]),
    .req_wdata(wdata[2]), .flush(flush[2]), .stall(stall[2]), .resp_valid(vld[2]),
    .resp_rdata(rdata[2]), .resp_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int wcfg(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Issue one access, wait for its response, and check latency, stall cycles and result.
  task automatic access(input int k, input logic rn, input logic wn, input logic [31:0] a,
                        input logic [31:0] d, input logic e_err, input logic [31:0] e_rd,
                        input bit hold, input string tag);
    int lat;
    int st;
    @(negedge clk);
    ren[k] = rn; wen[k] = wn; addr[k] = a; wdata[k] = d;
    #1;
    lat = 0; st = 0;
    while (!vld[k] && lat < 20) begin
      st += int'(stall[k]);
      @(negedge clk); #1;
      lat++;
    end
    last_resp = cyc;
    chk({tag, "_vld"},     {31'b0, vld[k]},   32'd1);
    chk({tag, "_lat"},     32'(lat),          32'(wcfg(k) + 1));
    chk({tag, "_stallcy"}, 32'(st),           32'(wcfg(k) + 1));
    chk({tag, "_stall0"},  {31'b0, stall[k]}, 32'd0);
    chk({tag, "_err"},     {31'b0, err[k]},   {31'b0, e_err});
    chk({tag, "_rdata"},   rdata[k],          e_rd);
    ren[k] = 1'b0; wen[k] = 1'b0;
    if (hold) begin
      @(negedge clk); #1;
      chk({tag, "_vldoff"}, {31'b0, vld[k]}, 32'd0);
      chk({tag, "_hold"},   rdata[k],        e_rd);
    end
  endtask

  initial begin
    int r1;
    int nv;
    rst_n = 3'b000; ren = '0; wen = '0; flush = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_vld%0d", i),   {31'b0, vld[i]},   32'd0);
      chk($sformatf("rst_err%0d", i),   {31'b0, err[i]},   32'd0);
      chk($sformatf("rst_rdata%0d", i), rdata[i],          32'd0);
      chk($sformatf("rst_stall%0d", i), {31'b0, stall[i]}, 32'd0);
    end
    ren[1] = 1'b1; #1;
    chk("rst_stall_follows_req", {31'b0, stall[1]}, 32'd1);
    ren[1] = 1'b0;
    @(negedge clk); rst_n = 3'b111;

    // WAIT_CYCLES=1: basic store/load, error cases
    access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, "w1_st10");
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, "w1_ld10");
    access(1, 1'b1, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0, 1'b0, "w1_ld_mis");
    access(1, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b0, "w1_ld_oor");
    access(1, 1'b0, 1'b1, 32'h12, 32'h12345678, 1'b1, 32'h0, 1'b0, "w1_st_mis");
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, "w1_ld10_again");
    access(1, 1'b0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, 32'h0, 1'b0, "w1_st20");
    access(1, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, "w1_rw20");
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hAAAA5555, 1'b0, "w1_ld20");

    // WAIT_CYCLES=0: back-to-back loads
    access(0, 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 32'h0, 1'b0, "w0_st0");
    access(0, 1'b0, 1'b1, 32'h4, 32'h22222222, 1'b0, 32'h0, 1'b0, "w0_st4");
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h11111111, 1'b0, "w0_ld0");
    r1 = last_resp;
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h22222222, 1'b0, "w0_ld4");
    chk("w0_resp_gap", 32'(last_resp - r1), 32'd2);

    // WAIT_CYCLES=3: flush in the second WAIT cycle
    access(2, 1'b0, 1'b1, 32'h40, 32'hCAFE0040, 1'b0, 32'h0, 1'b0, "w3_st40");
    @(negedge clk);
    wen[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'h99999999; #1;
    chk("w3_fl_stall_acc", {31'b0, stall[2]}, 32'd1);
    @(negedge clk); #1;
    chk("w3_fl_stall_w1", {31'b0, stall[2]}, 32'd1);
    @(negedge clk); flush[2] = 1'b1; #1;
    chk("w3_fl_stall_flush", {31'b0, stall[2]}, 32'd0);
    @(negedge clk); wen[2] = 1'b0; flush[2] = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      #1; nv += int'(vld[2]);
      @(negedge clk);
    end
    chk("w3_fl_novalid", 32'(nv), 32'd0);
    access(2, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'hCAFE0040, 1'b0, "w3_ld40_after_flush");

    // WAIT_CYCLES=3: reset during WAIT of a store
    access(2, 1'b0, 1'b1, 32'h44, 32'h44444444, 1'b0, 32'h0, 1'b0, "w3_st44");
    access(2, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h44444444, 1'b0, "w3_ld44");
    @(negedge clk);
    wen[2] = 1'b1; addr[2] = 32'h44; wdata[2] = 32'h55555555;
    @(negedge clk); #1;
    chk("w3_rst_pre_hold", rdata[2], 32'h44444444);
    #2; rst_n[2] = 1'b0; #1;
    chk("w3_rst_vld",   {31'b0, vld[2]},   32'd0);
    chk("w3_rst_rdata", rdata[2],          32'd0);
    chk("w3_rst_err",   {31'b0, err[2]},   32'd0);
    chk("w3_rst_stall", {31'b0, stall[2]}, 32'd1);
    @(negedge clk); wen[2] = 1'b0;
    @(negedge clk); rst_n[2] = 1'b1;
    access(2, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h44444444, 1'b0, "w3_ld44_after_rst");
    access(2, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'hCAFE0040, 1'b0, "w3_ld40_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
